// File: rtl/regfile_writeback_queue_pkg.sv
// Shared core types for the register-file write path: address/data widths and the queued write-back entry.
package rv_core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer-side request handshake and register-file write port of the write-back queue.
interface regfile_writeback_queue_if;
    import rv_core_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [XLEN-1:0]       in_data;
    logic                  wb_ready;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    // master drives requests and owns the write port; slave is the queue itself
    modport master (
        output in_valid, in_rd, in_data, wb_ready,
        input  in_ready, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_rd, in_data, wb_ready,
        output in_ready, wb_en, wb_rd, wb_data
    );
endinterface

// File: rtl/regfile_writeback_queue_fwd_match.sv
// Finds the youngest valid queued entry whose rd matches a source register and returns its data.
module wbq_fwd_match
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t             entries_i [DEPTH],
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    output logic                  hit_o,
    output logic [XLEN-1:0]       data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from the head so the last match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        if (rs_i != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_i + PTR_W'(k);
                if (valid_i[idx] && entries_i[idx].rd == rs_i) begin
                    hit_o  = 1'b1;
                    data_o = entries_i[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// FIFO of pending register write-backs draining into the single write port, with read-stage forwarding.
module regfile_writeback_queue
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_writeback_queue_if.slave  bus,
    input  logic [REG_ADDR_W-1:0]     rs1,
    input  logic [REG_ADDR_W-1:0]     rs2,
    output logic                      rs1_hit,
    output logic [XLEN-1:0]           rs1_fwd,
    output logic                      rs2_hit,
    output logic [XLEN-1:0]           rs2_fwd,
    output logic [PTR_W:0]            count,
    output logic                      empty,
    output logic                      full
);

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, store, pop;
    wb_entry_t        head_e;

    assign empty        = (count_q == '0);
    assign full         = (count_q == (PTR_W+1)'(DEPTH));
    assign count        = count_q;
    assign bus.in_ready = !full;

    assign push  = bus.in_valid && !full;
    // x0 requests complete the handshake but are dropped here
    assign store = push && (bus.in_rd != '0);
    assign pop   = !empty && bus.wb_ready;

    assign head_e      = mem_q[head_q];
    assign bus.wb_en   = pop;
    assign bus.wb_rd   = pop ? head_e.rd   : '0;
    assign bus.wb_data = pop ? head_e.data : '0;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (store) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (store && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !store) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[tail_q] <= '{rd: bus.in_rd, data: bus.in_data};
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs1 (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .rs_i      (rs1),
        .hit_o     (rs1_hit),
        .data_o    (rs1_fwd)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs2 (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .rs_i      (rs2),
        .hit_o     (rs2_hit),
        .data_o    (rs2_fwd)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for the write-back queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_regfile_writeback_queue;
    import rv_core_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [REG_ADDR_W-1:0] rs1, rs2;
    logic                  rs1_hit, rs2_hit;
    logic [XLEN-1:0]       rs1_fwd, rs2_fwd;
    logic [PTR_W:0]        count;
    logic                  empty, full;

    regfile_writeback_queue_if bus();

    regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_hit (rs1_hit),
        .rs1_fwd (rs1_fwd),
        .rs2_hit (rs2_hit),
        .rs2_fwd (rs2_fwd),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending {rd,data}; x0 never enters it.
    logic [36:0] mq[$];
    bit          model_live = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            model_live = 1;
        end else if (model_live) begin
            bit taking, giving;
            giving = (mq.size() > 0) && bus.wb_ready;
            taking = bus.in_valid && (mq.size() < DEPTH);
            if (giving) void'(mq.pop_front());
            if (taking && bus.in_rd != 0) mq.push_back({bus.in_rd, bus.in_data});
        end
    end

    function automatic logic [32:0] model_fwd(input logic [4:0] rs);
        if (rs == 0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][36:32] == rs) return {1'b1, mq[i][31:0]};
        return 33'd0;
    endfunction

    always @(negedge clk) begin
        if (model_live && rst_n) begin
            logic        e_en;
            logic [32:0] f1, f2;
            e_en = (mq.size() > 0) && bus.wb_ready;
            f1   = model_fwd(rs1);
            f2   = model_fwd(rs2);
            chk("m_wb_en",    32'(bus.wb_en),   32'(e_en));
            chk("m_wb_rd",    32'(bus.wb_rd),   e_en ? 32'(mq[0][36:32]) : 32'd0);
            chk("m_wb_data",  bus.wb_data,      e_en ? mq[0][31:0] : 32'd0);
            chk("m_count",    32'(count),       32'(mq.size()));
            chk("m_empty",    32'(empty),       32'(mq.size() == 0));
            chk("m_full",     32'(full),        32'(mq.size() == DEPTH));
            chk("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            chk("m_rs1_hit",  32'(rs1_hit),     32'(f1[32]));
            chk("m_rs1_fwd",  rs1_fwd,          f1[31:0]);
            chk("m_rs2_hit",  32'(rs2_hit),     32'(f2[32]));
            chk("m_rs2_fwd",  rs2_fwd,          f2[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_rd = 0; bus.in_data = 0; bus.wb_ready = 0;
        rs1 = 0; rs2 = 0;
        tick(); tick();
        rst_n = 1'b1;

        // idle after reset
        rs1 = 5'd3;
        repeat (5) tick();
        settle();
        chk("idle_wb_en", 32'(bus.wb_en), 0);
        chk("idle_empty", 32'(empty), 1);
        chk("idle_count", 32'(count), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_rs1_hit", 32'(rs1_hit), 0);

        // single write, one-cycle latency
        bus.wb_ready = 1; bus.in_valid = 1; bus.in_rd = 5; bus.in_data = 32'hDEADBEEF;
        tick(); bus.in_valid = 0; settle();
        chk("single_wb_en", 32'(bus.wb_en), 1);
        chk("single_wb_rd", 32'(bus.wb_rd), 5);
        chk("single_wb_data", bus.wb_data, 32'hDEADBEEF);
        tick(); settle();
        chk("single_after_en", 32'(bus.wb_en), 0);
        chk("single_after_count", 32'(count), 0);

        // fill with back-pressure
        bus.wb_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1; bus.in_rd = 5'(i); bus.in_data = 32'(i * 32'h11);
            tick();
        end
        bus.in_valid = 0; settle();
        chk("fill_full", 32'(full), 1);
        chk("fill_in_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1; bus.in_rd = 5'd9; bus.in_data = 32'h99;
        tick(); bus.in_valid = 0; settle();
        chk("fill_reject_count", 32'(count), 4);
        bus.wb_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_rd", 32'(bus.wb_rd), 32'(i));
            chk("drain_data", bus.wb_data, 32'(i * 32'h11));
            tick(); settle();
        end
        chk("drain_empty", 32'(empty), 1);

        // same-register forwarding picks the youngest
        bus.wb_ready = 0; rs1 = 5'd7;
        bus.in_valid = 1; bus.in_rd = 7; bus.in_data = 32'h100; tick();
        bus.in_rd = 7; bus.in_data = 32'h200; tick();
        bus.in_valid = 0; settle();
        chk("fwd_hit2", 32'(rs1_hit), 1);
        chk("fwd_data2", rs1_fwd, 32'h200);
        bus.wb_ready = 1;
        tick(); settle();
        chk("fwd_hit1", 32'(rs1_hit), 1);
        chk("fwd_data1", rs1_fwd, 32'h200);
        tick(); settle();
        chk("fwd_hit0", 32'(rs1_hit), 0);
        chk("fwd_data0", rs1_fwd, 0);

        // x0 accepted but never stored
        rs2 = 5'd0;
        bus.in_valid = 1; bus.in_rd = 0; bus.in_data = 32'hFFFFFFFF;
        #1;
        chk("x0_in_ready", 32'(bus.in_ready), 1);
        tick(); bus.in_valid = 0; settle();
        chk("x0_count", 32'(count), 0);
        chk("x0_wb_en", 32'(bus.wb_en), 0);
        chk("x0_rs2_hit", 32'(rs2_hit), 0);

        // reset discards queued writes
        bus.wb_ready = 0; rs1 = 5'd11; rs2 = 5'd12;
        for (int i = 10; i <= 12; i++) begin
            bus.in_valid = 1; bus.in_rd = 5'(i); bus.in_data = 32'hA0 + 32'(i);
            tick();
        end
        bus.in_valid = 0; settle();
        chk("rst_pre_count", 32'(count), 3);
        chk("rst_pre_rs2_fwd", rs2_fwd, 32'hAC);
        rst_n = 0; tick(); rst_n = 1; bus.wb_ready = 1; settle();
        chk("rst_count", 32'(count), 0);
        chk("rst_wb_en", 32'(bus.wb_en), 0);
        chk("rst_rs1_hit", 32'(rs1_hit), 0);
        repeat (3) begin
            tick(); settle();
            chk("rst_no_write", 32'(bus.wb_en), 0);
        end

        // wrap-around with concurrent pops
        for (int i = 1; i <= 10; i++) begin
            bus.in_valid = 1; bus.in_rd = 5'(i); bus.in_data = 32'h1000 + 32'(i);
            tick(); settle();
            chk("wrap_rd", 32'(bus.wb_rd), 32'(i));
            chk("wrap_data", bus.wb_data, 32'h1000 + 32'(i));
            chk("wrap_count", 32'(count), 1);
        end
        bus.in_valid = 0;
        tick(); settle();
        chk("wrap_final_count", 32'(count), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side companion to the 32x32 register file. Buffers register write-back requests from execute/load producers in a small FIFO.
- Drains the FIFO one entry per cycle into the register file's single write port (regWrite/writeReg/writeData).
- Gives the read stage a pending-write check and forwarding, so reads never return stale values while writes are still queued.

Parameters:
- DEPTH, 4, number of queued write-back entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), width of the read/write pointers.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer presents a write-back request.
- in_ready  output  1  queue can accept; equals !full.
- in_rd  input  5  destination register.
- in_data  input  32  value to write.
- wb_ready  input  1  write port free this cycle; 0 means the port is shared or stalled.
- wb_en  output  1  drives register file regWrite.
- wb_rd  output  5  drives writeReg.
- wb_data  output  32  drives writeData.
- rs1  input  5  read-stage source register 1.
- rs2  input  5  read-stage source register 2.
- rs1_hit  output  1  a queued entry targets rs1.
- rs1_fwd  output  32  youngest queued data for rs1.
- rs2_hit  output  1  a queued entry targets rs2.
- rs2_fwd  output  32  youngest queued data for rs2.
- count  output  PTR_W+1  occupancy.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset: on a clk edge with rst_n=0, clear pointers, count and all entry valid bits; entry data is don't-care.
  - After reset: in_ready=1, wb_en=0, wb_rd=0, wb_data=0, rsX_hit=0, rsX_fwd=0, count=0, empty=1, full=0.
  - Reset mid-operation discards queued writes; none reach the register file.
- Enqueue: an edge with in_valid & in_ready stores {in_rd, in_data} at the tail and advances the tail.
  - in_rd==0 is accepted (handshake completes) but not stored; x0 is never written.
- Dequeue: wb_en = !empty & wb_ready. wb_rd/wb_data are the head entry, combinational from entry flops.
  - When !wb_en, wb_rd and wb_data are 0.
  - An edge with wb_en=1 pops the head.
- Latency: a request accepted at edge N is visible on wb_* in cycle N+1 and written at edge N+1 if wb_ready=1.
- Simultaneous enqueue and dequeue: count unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (no pass-through).
  - When empty, the new request is not bypassed to wb_* in the same cycle.
- Ordering: strict FIFO; writes to the same rd retire oldest first.
- Pointer wrap-around: modulo DEPTH; count is tracked separately so full and empty are unambiguous.
- Forwarding:
  - rsX_hit=1 if any valid entry has rd==rsX.
  - rsX_fwd is the data of the youngest such entry (closest to the tail); 0 if no hit.
  - rsX==0 always gives hit=0, fwd=0.
  - Forwarding is combinational and covers only queued entries, not the in_* request of the same cycle.
  - The entry being popped in the current cycle still counts as a hit.
- No X propagation: outputs are defined at all times after the first reset.

Decomposition:
- Shared package rv_core_pkg:
  - REG_ADDR_W=5, XLEN=32.
  - wb_entry_t struct {logic [4:0] rd; logic [31:0] data}.
- One sub-module, wbq_fwd_match: given the entry array, valid bits, head pointer and a source register, returns hit and youngest data. Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset then idle: in_valid=0 for 5 cycles -> wb_en=0, empty=1, count=0, in_ready=1, rs1_hit=0.
- Single write: enqueue rd=5, data=0xDEADBEEF with wb_ready=1 -> next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF for exactly one cycle; count returns to 0.
- Fill and back-pressure: wb_ready=0, enqueue 4 entries rd=1..4 with data 0x11..0x44 -> full=1, in_ready=0; then a 5th request is not accepted. Raise wb_ready -> drains in order rd=1,2,3,4 over 4 cycles; empty=1 after.
- Same-register forwarding: wb_ready=0, enqueue rd=7/0x100 then rd=7/0x200, rs1=7 -> rs1_hit=1, rs1_fwd=0x200. After one pop, still 0x200. After the second pop, rs1_hit=0.
- x0 handling: enqueue rd=0, data=0xFFFFFFFF -> in_ready handshake completes, count stays 0, wb_en never asserts, rs2=0 gives rs2_hit=0.
- Reset mid-operation: 3 entries queued with wb_ready=0, assert rst_n=0 for one edge -> count=0, wb_en=0, no queued write ever appears on wb_*.
- Wrap-around: 10 consecutive enqueues with concurrent pops, rd=1..10 -> wb_rd sequence 1..10 with matching data; count never exceeds 1.
